// File: rtl/vec_wb_serializer.sv
// -----------------------------------------------------------------------------
// vec_wb_serializer
//
// Captures one full vector ALU result (LANES lane words, per-lane NZCV, lane
// enable mask and a base byte address) in a single valid/ready handshake, then
// drains the enabled lanes to a single-port data memory, one word write per
// accepted cycle, at base + 4*lane. After the last write a one-cycle done pulse
// is raised and the reduced NZCV of the enabled lanes is published on flags.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   upstream presents a vector
//   in_ready   serializer can accept a vector (IDLE and out of reset)
//   in_data    lane results, index 0 = lane 0
//   in_nzcv    per-lane flags, [3:0] = N,Z,C,V
//   in_mask    lane enable, 1 = write this lane
//   in_base    byte address of lane 0
//   mem_we     write request to data memory
//   mem_addr   write byte address
//   mem_wdata  write data
//   mem_ready  memory accepts the write this cycle
//   busy       a captured vector is not yet fully retired
//   done       one-cycle pulse when the vector is retired
//   flags      reduced NZCV of the last retired vector
// -----------------------------------------------------------------------------
module vec_wb_serializer #(
    parameter int bits   = 32,
    parameter int LANES  = 10,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [bits-1:0]   in_data [LANES-1:0],
    input  logic [3:0]        in_nzcv [LANES-1:0],
    input  logic [LANES-1:0]  in_mask,
    input  logic [ADDR_W-1:0] in_base,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [bits-1:0]   mem_wdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic [3:0]        flags
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [bits-1:0]   r_data [LANES-1:0];
    logic [LANES-1:0]  r_pend;
    logic [ADDR_W-1:0] r_base;
    logic [3:0]        r_red;
    logic [3:0]        r_flags;

    logic [LANES-1:0]  w_n_vec;
    logic [LANES-1:0]  w_z_vec;
    logic [LANES-1:0]  w_c_vec;
    logic [LANES-1:0]  w_v_vec;
    logic [3:0]        w_red;
    logic [LANES-1:0]  w_lane_onehot;
    logic [LANES-1:0]  w_pend_after;
    logic [LANE_W-1:0] w_lane;
    logic              w_capture;
    logic              w_accept;

    // Per-lane flag contributions. Disabled lanes are neutral for each
    // reduction: 0 for the OR terms, 1 for the Z AND term. An all-zero mask
    // therefore reduces to 4'b0100 without a special case.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane_flags
            assign w_n_vec[gi] =  in_mask[gi] & in_nzcv[gi][3];
            assign w_z_vec[gi] = ~in_mask[gi] | in_nzcv[gi][2];
            assign w_c_vec[gi] =  in_mask[gi] & in_nzcv[gi][1];
            assign w_v_vec[gi] =  in_mask[gi] & in_nzcv[gi][0];
        end
    endgenerate

    assign w_red = {|w_n_vec, &w_z_vec, |w_c_vec, |w_v_vec};

    // Lowest pending lane: isolate the lowest set bit, then encode it. Lanes
    // that are not pending never get a cycle.
    assign w_lane_onehot = r_pend & (~r_pend + 1'b1);
    assign w_pend_after  = r_pend & ~w_lane_onehot;

    always_comb begin
        w_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (w_lane_onehot[i]) begin
                w_lane = w_lane | LANE_W'(i);
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE) & rst_n;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign mem_we    = (r_state == S_WRITE);
    assign w_capture = in_valid & in_ready;
    // mem_ready outside WRITE is ignored because mem_we gates it.
    assign w_accept  = mem_we & mem_ready;

    // Address and data depend only on registered state, so they stay stable
    // across any number of stalled cycles. Forced to zero outside WRITE.
    assign mem_addr  = mem_we ? (r_base + ADDR_W'({w_lane, 2'b00})) : '0;
    assign mem_wdata = mem_we ? r_data[w_lane] : '0;
    assign flags     = r_flags;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_state_next = (|in_mask) ? S_WRITE : S_DONE;
                end
            end
            S_WRITE: begin
                if (w_accept && (w_pend_after == '0)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
            r_base  <= '0;
            r_red   <= '0;
            r_flags <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                for (int i = 0; i < LANES; i++) begin
                    r_data[i] <= in_data[i];
                end
                r_base <= in_base;
                r_red  <= w_red;
                r_pend <= in_mask;
            end else if (w_accept) begin
                r_pend <= w_pend_after;
            end
            // Publish flags as DONE is entered so they are valid alongside
            // the done pulse. A zero-mask vector goes straight from IDLE, so
            // its reduction is taken from the inputs being captured.
            if ((w_state_next == S_DONE) && (r_state != S_DONE)) begin
                r_flags <= (r_state == S_IDLE) ? w_red : r_red;
            end
        end
    end

endmodule

// File: tb/tb_vec_wb_serializer.sv
module tb_vec_wb_serializer;

    localparam int BITS   = 32;
    localparam int LANES  = 10;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BITS-1:0]   in_data [LANES-1:0];
    logic [3:0]        in_nzcv [LANES-1:0];
    logic [LANES-1:0]  in_mask = '0;
    logic [ADDR_W-1:0] in_base = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BITS-1:0]   mem_wdata;
    logic              mem_ready = 1'b1;
    logic              busy;
    logic              done;
    logic [3:0]        flags;

    int n_pass  = 0;
    int n_total = 0;
    int wr_cnt  = 0;

    vec_wb_serializer #(
        .bits   (BITS),
        .LANES  (LANES),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_nzcv   (in_nzcv),
        .in_mask   (in_mask),
        .in_base   (in_base),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    // Counts accepted memory writes.
    always @(posedge clk) begin
        if (mem_we && mem_ready) wr_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
        $display("write %s: we=%0b addr=0x%08h data=0x%08h (exp 0x%08h 0x%08h)",
                 tag, mem_we, mem_addr, mem_wdata, addr, data);
        chk({tag, "_we"}, {31'd0, mem_we}, 32'd1);
        chk({tag, "_addr"}, mem_addr, addr);
        chk({tag, "_data"}, mem_wdata, data);
    endtask

    task automatic set_data(input logic [31:0] dbase);
        for (int i = 0; i < LANES; i++) in_data[i] = dbase + 32'(i);
    endtask

    task automatic present(input logic [31:0] base, input logic [LANES-1:0] mask,
                           input logic [31:0] dbase);
        in_base  = base;
        in_mask  = mask;
        set_data(dbase);
        in_valid = 1'b1;
        $display("present base=0x%08h mask=0x%03h data0=0x%08h", base, mask, dbase);
    endtask

    initial begin
        for (int i = 0; i < LANES; i++) in_nzcv[i] = 4'b0100;
        in_nzcv[3] = 4'b1000;
        in_nzcv[7] = 4'b0001;
        set_data(32'h0);

        // ---------------- reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
        chk("rst_busy",     {31'd0, busy},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_flags",    {28'd0, flags},    32'd0);
        chk("rst_mem_addr", mem_addr,          32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // ---------------- full vector, mem_ready high
        present(32'h1000, 10'h3FF, 32'h100);
        @(negedge clk);
        in_valid = 1'b0;
        set_data(32'hDEAD_0000);  // must not affect the vector in flight
        for (int i = 0; i < LANES; i++) begin
            if (i > 0) @(negedge clk);
            chk_wr("full", 32'h1000 + 32'(4 * i), 32'h100 + 32'(i));
            chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        $display("full done=%0b flags=%04b", done, flags);
        chk("full_done",   {31'd0, done},   32'd1);
        chk("full_we_off", {31'd0, mem_we}, 32'd0);
        chk("full_flags",  {28'd0, flags},  32'h9);
        chk("full_rdy_lo", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("full_done_off", {31'd0, done},     32'd0);
        chk("full_rdy_hi",   {31'd0, in_ready}, 32'd1);
        chk("full_busy_off", {31'd0, busy},     32'd0);

        // ---------------- sparse mask 0x205
        present(32'h2000, 10'h205, 32'h200);
        @(negedge clk);
        in_valid = 1'b0;
        chk("sparse_flags_hold", {28'd0, flags}, 32'h9);
        chk_wr("sparse_l0", 32'h2000, 32'h200);
        @(negedge clk);
        chk_wr("sparse_l2", 32'h2008, 32'h202);
        @(negedge clk);
        chk_wr("sparse_l9", 32'h2024, 32'h209);
        @(negedge clk);
        $display("sparse done=%0b flags=%04b", done, flags);
        chk("sparse_done",  {31'd0, done},  32'd1);
        chk("sparse_flags", {28'd0, flags}, 32'h4);
        @(negedge clk);
        chk("sparse_rdy", {31'd0, in_ready}, 32'd1);

        // ---------------- backpressure on lane 4
        wr_cnt = 0;
        present(32'h3000, 10'h3FF, 32'h300);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk_wr("bp", 32'h3000 + 32'(4 * i), 32'h300 + 32'(i));
        end
        mem_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk_wr("bp_stall", 32'h3010, 32'h304);
        end
        mem_ready = 1'b1;
        for (int i = 5; i < LANES; i++) begin
            @(negedge clk);
            chk_wr("bp", 32'h3000 + 32'(4 * i), 32'h300 + 32'(i));
        end
        @(negedge clk);
        $display("bp done=%0b flags=%04b writes=%0d", done, flags, wr_cnt);
        chk("bp_done",   {31'd0, done}, 32'd1);
        chk("bp_flags",  {28'd0, flags}, 32'h9);
        chk("bp_writes", 32'(wr_cnt), 32'd10);
        @(negedge clk);
        chk("bp_rdy", {31'd0, in_ready}, 32'd1);

        // ---------------- mask zero
        wr_cnt = 0;
        present(32'h4000, 10'h000, 32'h400);
        @(negedge clk);
        in_valid = 1'b0;
        $display("mask0 done=%0b flags=%04b", done, flags);
        chk("m0_done",  {31'd0, done},   32'd1);
        chk("m0_we",    {31'd0, mem_we}, 32'd0);
        chk("m0_flags", {28'd0, flags},  32'h4);
        @(negedge clk);
        chk("m0_rdy",    {31'd0, in_ready}, 32'd1);
        chk("m0_writes", 32'(wr_cnt), 32'd0);

        // ---------------- address wrap
        present(32'hFFFF_FFF8, 10'h00F, 32'h500);
        @(negedge clk);
        in_valid = 1'b0;
        chk_wr("wrap0", 32'hFFFF_FFF8, 32'h500);
        @(negedge clk);
        chk_wr("wrap1", 32'hFFFF_FFFC, 32'h501);
        @(negedge clk);
        chk_wr("wrap2", 32'h0000_0000, 32'h502);
        @(negedge clk);
        chk_wr("wrap3", 32'h0000_0004, 32'h503);
        @(negedge clk);
        chk("wrap_done",  {31'd0, done}, 32'd1);
        chk("wrap_flags", {28'd0, flags}, 32'h8);
        @(negedge clk);

        // ---------------- reset mid-WRITE
        wr_cnt = 0;
        present(32'h6000, 10'h3FF, 32'h600);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            chk_wr("mid", 32'h6000 + 32'(4 * i), 32'h600 + 32'(i));
        end
        @(negedge clk);
        chk_wr("mid_l4", 32'h6010, 32'h604);
        rst_n = 1'b0;
        #1;
        $display("midrst we=%0b busy=%0b done=%0b flags=%04b", mem_we, busy, done, flags);
        chk("mid_we",    {31'd0, mem_we},   32'd0);
        chk("mid_busy",  {31'd0, busy},     32'd0);
        chk("mid_done",  {31'd0, done},     32'd0);
        chk("mid_rdy",   {31'd0, in_ready}, 32'd0);
        chk("mid_flags", {28'd0, flags},    32'd0);
        @(negedge clk);
        chk("mid_writes", 32'(wr_cnt), 32'd4);
        chk("mid_we2",    {31'd0, mem_we}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rdy", {31'd0, in_ready}, 32'd1);
        present(32'h7000, 10'h003, 32'h700);
        @(negedge clk);
        in_valid = 1'b0;
        chk_wr("post_l0", 32'h7000, 32'h700);
        @(negedge clk);
        chk_wr("post_l1", 32'h7004, 32'h701);
        @(negedge clk);
        chk("post_done",   {31'd0, done}, 32'd1);
        chk("post_flags",  {28'd0, flags}, 32'h4);
        chk("post_writes", 32'(wr_cnt), 32'd6);
        @(negedge clk);
        chk("post_rdy2", {31'd0, in_ready}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/vec_wb_serializer.md
# vec_wb_serializer

Vector writeback serializer placed directly downstream of the 10-lane vector ALU. It captures one full vector result (ten 32-bit lane words plus per-lane NZCV) in a single handshake. It then drains the enabled lanes to the single-port data memory as one word write per accepted cycle, at consecutive word addresses. After the last write it reports a reduced vector flag set to the control unit.

## Interface

Parameters:
- bits, 32, lane data width
- LANES, 10, number of vector lanes
- ADDR_W, 32, byte-address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  a vector result is presented
- in_ready  out  1  serializer can accept a vector
- in_data  in  bits x [LANES-1:0] (unpacked)  lane results, index 0 = lane 0
- in_nzcv  in  4 x [LANES-1:0] (unpacked)  per-lane flags, bit order N,Z,C,V = [3:0]
- in_mask  in  LANES  lane enable; 1 = write this lane
- in_base  in  ADDR_W  byte address of lane 0
- mem_we  out  1  write request to data memory
- mem_addr  out  ADDR_W  write byte address
- mem_wdata  out  bits  write data
- mem_ready  in  1  memory accepts the write this cycle
- busy  out  1  a captured vector is not yet fully retired
- done  out  1  one-cycle pulse when the vector is retired
- flags  out  4  reduced NZCV of the last retired vector

## Operation

- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture in_data, in_nzcv, in_mask and in_base into internal registers. Compute the reduced flags from the captured inputs.
  - If the mask is nonzero, go to WRITE with the pending mask equal to in_mask. Otherwise go to DONE.
- WRITE:
  - The current lane is the lowest set bit of the pending mask, selected by a priority encoder. Masked lanes cost zero cycles.
  - mem_we = 1, mem_addr = base + 4*lane (modulo 2^ADDR_W, wrap permitted), mem_wdata = captured lane word.
  - On mem_ready, clear that lane's pending bit. If no pending bits remain, go to DONE.
  - Without mem_ready, hold mem_addr and mem_wdata stable. There is no timeout.
- DONE:
  - done = 1 for exactly one cycle, flags updated, then go to IDLE.
- Flag reduction over enabled lanes:
  - N = OR of N.
  - Z = AND of Z.
  - C = OR of C.
  - V = OR of V.
  - Mask all zero gives flags = 4'b0100.
- flags holds its value until the next DONE.
- busy = (state != IDLE). in_ready = (state == IDLE) & rst_n.
- in_data and the other inputs are sampled only at capture. Later changes have no effect on the vector in flight.

## Timing

- Reset (rst_n low, asynchronous): state = IDLE, pending mask = 0, and every output forced to 0, including in_ready.
  - First capture is possible on the first rising edge with rst_n high.
- Latency: capture at edge T; the first mem_we is high in cycle T+1.
- With mem_ready tied high and k enabled lanes: writes occupy cycles T+1..T+k, done is high in T+k+1, and in_ready is high again in T+k+2.
- Mask all zero: done in T+1, in_ready in T+2.
- Throughput with mem_ready tied high and all lanes enabled: one vector per 12 cycles.
- in_ready is low in WRITE and DONE. in_valid in those states is ignored; the upstream holds its data.
- Reset during WRITE: mem_we drops asynchronously, remaining lanes are discarded, no done pulse, flags = 0.
- mem_ready while mem_we = 0 is ignored.

## Test plan

- Full vector, mem_ready = 1: lanes i = 0x100+i, base 0x1000, mask 0x3FF.
  - Writes 0x1000..0x1024 stride 4, data 0x100..0x109 over 10 consecutive cycles.
  - done in the next cycle, in_ready one cycle after done.
- Sparse mask 0x205 (lanes 0, 2, 9) -> exactly 3 writes at base+0, +8, +36, no idle cycles between them, done on the 4th cycle after capture.
- Backpressure: mem_ready low for 3 cycles on lane 4.
  - mem_addr and mem_wdata held constant during the stall.
  - Lane 4 written exactly once; total latency grows by 3.
- Flags: all enabled lanes Z = 1 except lane 3 with N = 1 and lane 7 with V = 1 -> flags = 4'b1001.
  - Mask 0 -> no writes, done at T+1, flags = 4'b0100.
- Address wrap: base 0xFFFFFFF8, mask 0x00F -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- rst_n asserted mid-WRITE after 4 writes -> mem_we, busy and done immediately 0, no further writes.
  - After release, a new vector is accepted normally.
